// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction-fetch front end. Owns the PC and runs a req/ack
//               handshake to a variable-latency instruction memory. Each
//               fetched word is buffered with its PC+4 in a small prefetch
//               FIFO, so memory latency is decoupled from decode stalls.
//               A taken branch or jump redirects the PC and discards both
//               buffered and in-flight instructions.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               pcWrite               - 0 = hazard stall, no new request
//               PcSrc, beqAdr         - taken branch and its target
//               jmp, jmpAdr           - jump and its word index
//               consume               - IF/ID write enable (pops FIFO head)
//               imem_req/addr/ack/data- instruction memory handshake
//               inst_valid, Inst,
//               nextInstAdr           - FIFO head (zeros when empty)
//               flush                 - one-cycle pulse after any redirect
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcWrite,
    input  logic        PcSrc,
    input  logic        jmp,
    input  logic [31:0] beqAdr,
    input  logic [25:0] jmpAdr,
    input  logic        consume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] Inst,
    output logic [31:0] nextInstAdr,
    output logic        flush
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Depth widened by one bit so occupancy-after-push comparisons cannot wrap
    localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_addr;
    logic               r_req;
    logic               r_flush;
    logic [63:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_redirect;
    logic [31:0]        w_target;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_nextAddr;
    logic [c_CNT_W:0]   w_occAfterPush;
    logic               w_spaceIdle;
    logic               w_spaceAfter;

    // Branch has priority over jump when both arrive together
    assign w_redirect = PcSrc | jmp;
    assign w_target   = PcSrc ? beqAdr : {4'b0000, jmpAdr, 2'b00};

    assign inst_valid  = (r_count != '0);
    assign Inst        = inst_valid ? r_mem[r_rdPtr][31:0]  : 32'h0;
    assign nextInstAdr = inst_valid ? r_mem[r_rdPtr][63:32] : 32'h0;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign flush       = r_flush;

    // A redirect suppresses both the accepting push and the decoder's pop
    assign w_push     = (r_state == c_REQ) && imem_ack && !w_redirect;
    assign w_pop      = consume && inst_valid && !w_redirect;
    assign w_nextAddr = r_addr + 32'd4;

    // In IDLE nothing is outstanding, so occupancy alone decides
    assign w_spaceIdle = ({1'b0, r_count} < c_DEPTH_EXT) && pcWrite && !w_redirect;

    // Occupancy after this cycle's push and any same-cycle pop; a follow-on
    // request is only allowed if that leaves room for its data
    assign w_occAfterPush = {1'b0, r_count} + (c_CNT_W + 1)'(1) - (c_CNT_W + 1)'(w_pop);
    assign w_spaceAfter   = (w_occAfterPush < c_DEPTH_EXT) && pcWrite;

    // ------------------------------------------------------------------
    // Prefetch FIFO: circular buffer, pointers wrap on power-of-two depth
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset; validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wrPtr] <= {w_nextAddr, imem_data};
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM with registered request outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= 32'h0;
            r_req   <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            case (r_state)
                c_IDLE: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end else if (w_spaceIdle) begin
                        r_state <= c_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                c_REQ: begin
                    if (imem_ack) begin
                        if (w_redirect) begin
                            // Returning word belongs to the abandoned path
                            r_pc    <= w_target;
                            r_state <= c_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_pc <= w_nextAddr;
                            if (w_spaceAfter) begin
                                // Back-to-back fetch, request stays asserted
                                r_addr <= w_nextAddr;
                            end else begin
                                r_state <= c_IDLE;
                                r_req   <= 1'b0;
                            end
                        end
                    end else if (w_redirect) begin
                        // Memory must still complete the old request
                        r_pc    <= w_target;
                        r_state <= c_DROP;
                    end
                end
                c_DROP: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_ack) begin
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench for fetch_prefetch_unit. A memory model
//               answers requests with addr ^ key after a programmable latency;
//               a scoreboard queue holds the expected {PC+4, word} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcWrite;
    logic        PcSrc;
    logic        jmp;
    logic [31:0] beqAdr;
    logic [25:0] jmpAdr;
    logic        consume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] Inst;
    logic [31:0] nextInstAdr;
    logic        flush;

    logic        forceAck;
    logic [31:0] key;
    int          latency;
    int          waitCnt;
    int          checks;
    int          failures;
    logic [63:0] sbQ[$];

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pcWrite     (pcWrite),
        .PcSrc       (PcSrc),
        .jmp         (jmp),
        .beqAdr      (beqAdr),
        .jmpAdr      (jmpAdr),
        .consume     (consume),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst_valid  (inst_valid),
        .Inst        (Inst),
        .nextInstAdr (nextInstAdr),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    // Memory model: ack once the request has waited 'latency' cycles
    assign imem_ack  = forceAck | (imem_req & (waitCnt >= latency));
    assign imem_data = imem_addr ^ key;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
        else                       waitCnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: samples mid-cycle, pushes accepted fetches, pops on consume
    task automatic monitor_loop();
        logic prevRedir = 1'b0;
        logic dropping  = 1'b0;
        logic redir;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbQ.delete();
                prevRedir = 1'b0;
                dropping  = 1'b0;
            end else begin
                redir = PcSrc | jmp;
                checks++;
                if (flush !== prevRedir) begin
                    failures++;
                    $display("FAIL flush_pulse t=%0t got=%b exp=%b", $time, flush, prevRedir);
                end
                checks++;
                if (inst_valid !== (sbQ.size() != 0)) begin
                    failures++;
                    $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid, sbQ.size() != 0);
                end else if (!inst_valid) begin
                    checks++;
                    if (Inst !== 32'h0 || nextInstAdr !== 32'h0) begin
                        failures++;
                        $display("FAIL empty_outputs t=%0t got=%h/%h exp=0/0", $time, nextInstAdr, Inst);
                    end
                end
                if (inst_valid && sbQ.size() != 0) begin
                    checks++;
                    if ({nextInstAdr, Inst} !== sbQ[0]) begin
                        failures++;
                        $display("FAIL head_pair t=%0t got=%h/%h exp=%h/%h", $time,
                                 nextInstAdr, Inst, sbQ[0][63:32], sbQ[0][31:0]);
                    end
                    if (consume && !redir) void'(sbQ.pop_front());
                end
                if (imem_req && imem_ack) begin
                    if (!redir && !dropping) sbQ.push_back({imem_addr + 32'd4, imem_addr ^ key});
                    dropping = 1'b0;
                end else if (imem_req && redir) begin
                    dropping = 1'b1;
                end
                if (redir) sbQ.delete();
                prevRedir = redir;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pcWrite = 1'b0; PcSrc = 1'b0; jmp = 1'b0;
        consume = 1'b0; forceAck = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic level, input string name);
        int n = 0;
        while (imem_req !== level && n < 50) begin tick(); n++; end
        checks++;
        if (imem_req !== level) begin
            failures++;
            $display("FAIL %s_timeout got=%b exp=%b", name, imem_req, level);
        end
    endtask

    task automatic test_reset();
        key = 32'h0; latency = 0;
        rst = 1'b1; pcWrite = 1'b0; PcSrc = 1'b0; jmp = 1'b0; consume = 1'b0;
        forceAck = 1'b0; beqAdr = 32'h0; jmpAdr = 26'h0;
        tick(); tick();
        checks++;
        if ({imem_req, imem_addr, inst_valid, Inst, nextInstAdr, flush} !== 98'h0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b addr=%h v=%b inst=%h nia=%h fl=%b exp=all0",
                     imem_req, imem_addr, inst_valid, Inst, nextInstAdr, flush);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int reqSeen = 0;
        logic [31:0] expAddr = 32'h0;
        key = 32'h0; latency = 0;
        do_reset();
        consume = 1'b1; pcWrite = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (imem_req === 1'b1) begin
                reqSeen++;
                checks++;
                if (imem_addr !== expAddr) begin
                    failures++;
                    $display("FAIL stream_addr got=%h exp=%h", imem_addr, expAddr);
                end
                expAddr += 32'd4;
            end
        end
        checks++;
        if (reqSeen !== 8) begin
            failures++;
            $display("FAIL stream_req_count got=%0d exp=8", reqSeen);
        end
    endtask

    task automatic test_fill();
        int pushes = 0;
        key = 32'h1234_0000; latency = 0;
        do_reset();
        pcWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_ack === 1'b1) pushes++;
        end
        checks++;
        if (pushes !== 4) begin
            failures++;
            $display("FAIL fill_push_count got=%0d exp=4", pushes);
        end
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_full_state got req=%b v=%b exp req=0 v=1", imem_req, inst_valid);
        end
        consume = 1'b1;
        tick();
        consume = 1'b0;
        wait_req(1'b1, "fill_refetch");
        checks++;
        if (imem_addr !== 32'd16) begin
            failures++;
            $display("FAIL fill_refetch_addr got=%h exp=%h", imem_addr, 32'd16);
        end
    endtask

    task automatic test_redirect();
        int n = 0;
        key = 32'h00AB_0000; latency = 3;
        do_reset();
        pcWrite = 1'b1;
        while (imem_ack !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        PcSrc = 1'b1; beqAdr = 32'h40;
        tick();
        PcSrc = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL redirect_drop got v=%b fl=%b req=%b addr=%h exp v=0 fl=1 req=1 addr=4",
                     inst_valid, flush, imem_req, imem_addr);
        end
        wait_req(1'b0, "redirect_drain");
        wait_req(1'b1, "redirect_refetch");
        checks++;
        if (imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redirect_addr got=%h exp=%h", imem_addr, 32'h40);
        end
        n = 0;
        while (inst_valid !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (Inst !== (32'h40 ^ 32'h00AB_0000) || nextInstAdr !== 32'h44) begin
            failures++;
            $display("FAIL redirect_first_pair got=%h/%h exp=%h/%h",
                     nextInstAdr, Inst, 32'h44, 32'h40 ^ 32'h00AB_0000);
        end
    endtask

    task automatic test_branch_priority();
        key = 32'h0; latency = 2;
        do_reset();
        pcWrite = 1'b1;
        wait_req(1'b1, "prio_first");
        PcSrc = 1'b1; jmp = 1'b1; beqAdr = 32'h80; jmpAdr = 26'h10;
        tick();
        PcSrc = 1'b0; jmp = 1'b0;
        wait_req(1'b0, "prio_drain");
        wait_req(1'b1, "prio_refetch");
        checks++;
        if (imem_addr !== 32'h80) begin
            failures++;
            $display("FAIL prio_addr got=%h exp=%h", imem_addr, 32'h80);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int reqDuringStall = 0;
        key = 32'h5A00_0000; latency = 3;
        do_reset();
        pcWrite = 1'b1;
        wait_req(1'b1, "stall_first");
        pcWrite = 1'b0;
        while (imem_ack !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || Inst !== 32'h5A00_0000 || nextInstAdr !== 32'h4) begin
            failures++;
            $display("FAIL stall_complete got req=%b v=%b pair=%h/%h exp req=0 v=1 pair=4/5a000000",
                     imem_req, inst_valid, nextInstAdr, Inst);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req !== 1'b0) reqDuringStall++;
        end
        checks++;
        if (reqDuringStall !== 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d exp=0", reqDuringStall);
        end
        pcWrite = 1'b1;
        wait_req(1'b1, "stall_resume");
        checks++;
        if (imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL stall_resume_addr got=%h exp=%h", imem_addr, 32'h4);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        key = 32'h0F0F_0000; latency = 2;
        do_reset();
        pcWrite = 1'b1;
        while (!(inst_valid === 1'b1 && imem_req === 1'b1) && n < 50) begin tick(); n++; end
        checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup got v=%b req=%b exp v=1 req=1", inst_valid, imem_req);
        end
        rst = 1'b1; pcWrite = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({imem_req, imem_addr, inst_valid, Inst, nextInstAdr, flush} !== 98'h0) begin
            failures++;
            $display("FAIL midreset_outputs got req=%b addr=%h v=%b inst=%h nia=%h fl=%b exp=all0",
                     imem_req, imem_addr, inst_valid, Inst, nextInstAdr, flush);
        end
        forceAck = 1'b1;
        tick(); tick();
        forceAck = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL late_ack_ignored got v=%b req=%b exp v=0 req=0", inst_valid, imem_req);
        end
        pcWrite = 1'b1;
        wait_req(1'b1, "midreset_refetch");
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL midreset_addr got=%h exp=%h", imem_addr, 32'h0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        waitCnt  = 0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_stream();
        test_fill();
        test_redirect();
        test_branch_priority();
        test_stall();
        test_reset_mid();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake to a variable-latency instruction memory.
- Buffers fetched words with their PC+4 in a small FIFO, which decouples memory latency from decode stalls.
- Redirects on taken branch or jump, discarding buffered and in-flight instructions.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pcWrite  input  1  0 = hazard stall; no new memory request issued
PcSrc  input  1  taken branch from ID; redirect to beqAdr
jmp  input  1  jump from control; redirect to {4'b0000, jmpAdr, 2'b00}
beqAdr  input  32  branch target
jmpAdr  input  26  jump word index
consume  input  1  IF/ID write enable; pops FIFO head when inst_valid
imem_req  output  1  memory request, held until imem_ack
imem_addr  output  32  request address, stable while imem_req=1
imem_ack  input  1  sampled at clock edge while imem_req=1; imem_data valid that cycle
imem_data  input  32  instruction word
inst_valid  output  1  FIFO non-empty
Inst  output  32  head instruction; 32'h0 (NOP) when empty
nextInstAdr  output  32  head PC+4; 32'h0 when empty
flush  output  1  registered; pulses 1 cycle after any redirect (kills IF/ID contents)

Behaviour:
- Reset, synchronous, priority over all inputs:
  - pc=RESET_PC, FIFO empty, state IDLE.
  - imem_req=0, imem_addr=0, inst_valid=0, Inst=0, nextInstAdr=0, flush=0.
- Redirect = PcSrc|jmp. If both are set, PcSrc wins.
- Targets: PcSrc -> beqAdr. jmp -> {4'b0000, jmpAdr, 2'b00}.
- Redirect effects:
  - FIFO is cleared.
  - pc <= target.
  - flush=1 next cycle.
  - A same-cycle consume is ignored.
- Space rule: a request may issue only if occupancy + outstanding < DEPTH, pcWrite=1, and no redirect this cycle. At most one request is outstanding.
- FSM states: IDLE, REQ, DROP.
- IDLE:
  - If the space rule holds, go to REQ next cycle with imem_addr=pc and imem_req=1.
- REQ:
  - imem_req=1. imem_addr is held from entry.
  - On ack with no redirect:
    - Push {imem_addr+4, imem_data}; pc <= imem_addr+4.
    - If the space rule still holds (counting this push and any same-cycle pop), stay in REQ with imem_addr=imem_addr+4. This gives back-to-back fetches, 1 instruction/cycle when ack is immediate.
    - Otherwise go to IDLE.
  - On ack with redirect: discard data, go to IDLE.
  - No ack with redirect: go to DROP.
- DROP:
  - imem_req stays 1 with the old address.
  - On ack: discard data, go to IDLE.
  - A further redirect in DROP only updates pc; the later redirect wins.
- FIFO:
  - Circular buffer with wrapping read/write pointers plus a count.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty-with-push. Push at empty is not visible until the next cycle (no bypass).
  - Pop occurs when consume=1, inst_valid=1, and no redirect.
- Latency: minimum reset-to-first inst_valid is 3 cycles with an immediate ack (IDLE -> REQ -> push visible).
- pcWrite=0 never cancels the outstanding request. It completes and is pushed.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

Test Plan:
- Reset, then imem_ack tied to imem_req with data=addr, consume=1 -> imem_addr 0,4,8,...; Inst/nextInstAdr pairs (0,4), (4,8), (8,12) on consecutive cycles; flush never set.
- consume=0, immediate ack, DEPTH=4 -> exactly 4 pushes, then imem_req=0 and inst_valid=1. Then consume=1 for one cycle -> one new request to address 16.
- 3-cycle ack latency, PcSrc=1 with beqAdr=32'h40 while in REQ -> FIFO empty next cycle, flush pulse, old ack data discarded, next request address 32'h40, first pushed pair (32'h44, data).
- PcSrc=1 and jmp=1 same cycle, beqAdr=32'h80, jmpAdr=26'h10 -> next request at 32'h80, not 32'h40.
- pcWrite=0 while REQ outstanding -> that fetch is pushed on ack, no further request until pcWrite=1.
- rst asserted mid-REQ with entries in FIFO -> next cycle all outputs 0, FIFO empty, the following request at RESET_PC; a late ack while imem_req=0 is ignored.
